// File: rtl/camera_pkg.sv
// Shared camera-side definitions: readout FSM state encoding, default sample
// width and the active-low NRE encoding used by the exposure-control FSM.
package camera_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_STREAM  = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 8;

  // NRE lines are active low: 0 selects the row for readout.
  localparam logic NRE_ACTIVE = 1'b0;
  localparam logic NRE_IDLE   = 1'b1;

  // Column index width, never narrower than one bit.
  function automatic int col_w(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

endpackage

// File: rtl/pixel_readout_capture_if.sv
// Readout-side and stream-side signals of the pixel capture block.
// slave: the capture block; master: the exposure FSM plus downstream sink.
interface pixel_readout_capture_if import camera_pkg::*; #(
  parameter int COLS   = 2,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic                     Erase;
  logic                     Expose;
  logic                     NRE_1;
  logic                     NRE_2;
  logic                     ADC;
  logic [DATA_W-1:0]        Pix_data;
  logic                     Out_ready;
  logic                     Out_valid;
  logic [DATA_W-1:0]        Out_data;
  logic                     Out_row;
  logic [col_w(COLS)-1:0]   Out_col;
  logic                     Frame_done;
  logic                     Frame_err;
  logic                     Busy;

  modport slave (
    input  Erase, Expose, NRE_1, NRE_2, ADC, Pix_data, Out_ready,
    output Out_valid, Out_data, Out_row, Out_col, Frame_done, Frame_err, Busy
  );

  modport master (
    output Erase, Expose, NRE_1, NRE_2, ADC, Pix_data, Out_ready,
    input  Out_valid, Out_data, Out_row, Out_col, Frame_done, Frame_err, Busy
  );

endinterface

// File: rtl/pixel_frame_buffer.sv
// 2 x COLS register file holding one captured frame: one write port,
// one combinational read port. Contents are not reset.
module pixel_frame_buffer import camera_pkg::*; #(
  parameter int COLS   = 2,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic                   wr_row,
  input  logic [col_w(COLS)-1:0] wr_col,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_row,
  input  logic [col_w(COLS)-1:0] rd_col,
  output logic [DATA_W-1:0]      rd_data
);

  localparam int AW = (2 * COLS > 1) ? $clog2(2 * COLS) : 1;

  logic [DATA_W-1:0] mem [2*COLS];
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;

  assign wr_addr = AW'(int'(wr_row) * COLS + int'(wr_col));
  assign rd_addr = AW'(int'(rd_row) * COLS + int'(rd_col));
  assign rd_data = mem[rd_addr];

  // Sample write port.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/pixel_readout_capture.sv
// Captures one 2-row frame of ADC samples driven by the exposure FSM's
// Erase/Expose/NRE/ADC lines, then streams it out in raster order.
module pixel_readout_capture import camera_pkg::*; #(
  parameter int COLS   = 2,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    Clk,
  input  logic                    Reset,
  pixel_readout_capture_if.slave  bus
);

  localparam int CW    = col_w(COLS);
  localparam int CNT_W = $clog2(COLS + 1);
  localparam int CAP_W = $clog2(2 * COLS + 1);
  localparam logic [CNT_W-1:0] ROW_FULL = CNT_W'(COLS);
  localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(2 * COLS - 1);
  localparam logic [CW-1:0]    COL_LAST = CW'(COLS - 1);

  state_t            state, state_nxt;
  logic              adc_p1;
  logic              adc_rise;
  logic [CNT_W-1:0]  col1, col2;
  logic [CAP_W-1:0]  cap_cnt;
  logic              row1_sel, row2_sel;
  logic              we;
  logic              wr_row;
  logic [CW-1:0]     wr_col;
  logic              err_set;
  logic              cnt_clear;
  logic              rd_row;
  logic [CW-1:0]     rd_col;
  logic [DATA_W-1:0] rd_data;
  logic              out_last;
  logic              xfer;

  // A sample is taken in the first cycle ADC is seen high.
  assign adc_rise  = bus.ADC & ~adc_p1;
  assign row1_sel  = (bus.NRE_1 == NRE_ACTIVE) && (bus.NRE_2 == NRE_IDLE);
  assign row2_sel  = (bus.NRE_2 == NRE_ACTIVE) && (bus.NRE_1 == NRE_IDLE);
  assign out_last  = bus.Out_row && (bus.Out_col == COL_LAST);
  assign xfer      = bus.Out_valid && bus.Out_ready;
  assign cnt_clear = bus.Erase || (state == ST_IDLE) ||
                     ((state == ST_CAPTURE) && bus.Expose);
  assign bus.Busy  = (state != ST_IDLE);

  pixel_frame_buffer #(.COLS(COLS), .DATA_W(DATA_W)) u_buf (
    .clk     (Clk),
    .we      (we),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (bus.Pix_data),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  // Decide whether the current ADC edge is stored and where; a restart
  // request (Expose) or an abort (Erase) wins over the sample.
  always_comb begin
    we     = 1'b0;
    wr_row = 1'b0;
    wr_col = '0;
    if ((state == ST_CAPTURE) && adc_rise && !bus.Erase && !bus.Expose) begin
      if (row1_sel && (col1 < ROW_FULL)) begin
        we     = 1'b1;
        wr_row = 1'b0;
        wr_col = CW'(col1);
      end else if (row2_sel && (col2 < ROW_FULL)) begin
        we     = 1'b1;
        wr_row = 1'b1;
        wr_col = CW'(col2);
      end
    end
  end

  // Flag ADC edges that arrive where no sample may be taken.
  always_comb begin
    err_set = 1'b0;
    if (!bus.Erase && adc_rise) begin
      case (state)
        ST_ARMED:   err_set = 1'b1;
        ST_CAPTURE: err_set = !bus.Expose && !we;
        ST_STREAM:  err_set = 1'b1;
        default:    err_set = 1'b0;
      endcase
    end
  end

  // Next-state logic; Erase overrides every other event.
  always_comb begin
    state_nxt = state;
    if (bus.Erase) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (bus.Expose) state_nxt = ST_ARMED;
        ST_ARMED:   if (!bus.Expose) state_nxt = ST_CAPTURE;
        ST_CAPTURE: begin
          if (bus.Expose)                      state_nxt = ST_ARMED;
          else if (we && (cap_cnt == CAP_LAST)) state_nxt = ST_STREAM;
        end
        ST_STREAM:  if (xfer && out_last) state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register and ADC edge register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= ST_IDLE;
      adc_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      adc_p1 <= bus.ADC;
    end
  end

  // Per-row column counters and total capture count.
  always_ff @(posedge Clk) begin
    if (Reset || cnt_clear) begin
      col1    <= '0;
      col2    <= '0;
      cap_cnt <= '0;
    end else if (we) begin
      if (!wr_row) col1 <= col1 + CNT_W'(1);
      else         col2 <= col2 + CNT_W'(1);
      cap_cnt <= cap_cnt + CAP_W'(1);
    end
  end

  // Sticky protocol error, cleared only when a new exposure is armed.
  always_ff @(posedge Clk) begin
    if (Reset)                                              bus.Frame_err <= 1'b0;
    else if ((state == ST_IDLE) && (state_nxt == ST_ARMED)) bus.Frame_err <= 1'b0;
    else if (err_set)                                       bus.Frame_err <= 1'b1;
  end

  // Output stream: rd_row/rd_col point at the next pixel to present; the
  // output registers reload on entry and after every transfer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.Out_valid  <= 1'b0;
      bus.Out_data   <= '0;
      bus.Out_row    <= 1'b0;
      bus.Out_col    <= '0;
      bus.Frame_done <= 1'b0;
      rd_row         <= 1'b0;
      rd_col         <= '0;
    end else begin
      bus.Frame_done <= 1'b0;
      if (bus.Erase || (state != ST_STREAM)) begin
        bus.Out_valid <= 1'b0;
        rd_row        <= 1'b0;
        rd_col        <= '0;
      end else if (!bus.Out_valid || bus.Out_ready) begin
        if (bus.Out_valid && out_last) begin
          bus.Out_valid  <= 1'b0;
          bus.Frame_done <= 1'b1;
        end else begin
          bus.Out_valid <= 1'b1;
          bus.Out_data  <= rd_data;
          bus.Out_row   <= rd_row;
          bus.Out_col   <= rd_col;
          if (rd_col == COL_LAST) begin
            rd_col <= '0;
            rd_row <= 1'b1;
          end else begin
            rd_col <= rd_col + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/pixel_readout_capture.md
Name: pixel_readout_capture

Overview:
- Sensor-side receiver for the exposure-control FSM's readout interface: consumes Erase, Expose, NRE_1, NRE_2 and ADC.
- Captures one 2-row × COLS frame of ADC samples into an internal buffer.
- Streams the frame out in raster order over a valid/ready handshake.
- Sits between the exposure-control FSM and the image-processing/storage path.

Parameters:
- COLS, 2, pixels per row; rows are fixed at 2, one per NRE line.
- DATA_W, 8, ADC sample width.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Erase  in  1  high = pixel array erase; aborts and clears the block.
- Expose  in  1  high = exposure in progress.
- NRE_1  in  1  active-low row-1 read enable.
- NRE_2  in  1  active-low row-2 read enable.
- ADC  in  1  conversion strobe; a sample is taken on its 0→1 edge.
- Pix_data  in  DATA_W  ADC result, valid in the cycle ADC rises.
- Out_ready  in  1  downstream ready.
- Out_valid  out  1  pixel available on Out_data.
- Out_data  out  DATA_W  pixel value.
- Out_row  out  1  row index: 0 = row 1, 1 = row 2.
- Out_col  out  $clog2(COLS) (min 1)  column index.
- Frame_done  out  1  one-cycle pulse after the last pixel transfer.
- Frame_err  out  1  sticky protocol-error flag.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ARMED, CAPTURE, STREAM.
- Reset:
  - State = IDLE.
  - All outputs 0.
  - Column counters, capture count and edge register cleared.
  - Buffer contents don't-care.
- Edge detect: ADC is registered once. adc_rise = ADC & ~ADC_q, so a sample is taken in the same cycle ADC is first seen high.
- IDLE:
  - Expose=1 → ARMED.
  - Clear per-row column counters, capture count and Frame_err.
  - Ignore ADC edges.
- ARMED:
  - Stay while Expose=1.
  - Expose 1→0 → CAPTURE.
  - An ADC edge here sets Frame_err and is discarded.
- CAPTURE, on each adc_rise:
  - NRE_1=0 and NRE_2=1: store Pix_data at buf[0][col1], col1++.
  - NRE_2=0 and NRE_1=1: store at buf[1][col2], col2++.
  - Both low or both high: set Frame_err, discard the sample.
  - Row already holds COLS samples: set Frame_err, discard (no wrap, no overwrite).
  - Rows may be read in either order and interleaved.
  - Once 2*COLS samples are stored (including the edge that stores the last one), enter STREAM on the next cycle.
- STREAM:
  - Out_valid=1 holding buf[r][c] with Out_row=r, Out_col=c, starting at (0,0). Order: (0,0)…(0,COLS-1),(1,0)…(1,COLS-1).
  - Transfer occurs when Out_valid & Out_ready. Advance the index on the next edge.
  - Out_data, Out_row and Out_col stay stable while Out_valid=1 and Out_ready=0.
  - After the final transfer: Frame_done pulses for 1 cycle, Out_valid=0, state → IDLE.
  - ADC edges in STREAM set Frame_err and are discarded.
- Outputs are registered. First Out_valid is asserted 1 cycle after STREAM entry.
- Erase=1 in any state: next state = IDLE, Out_valid=0, counters cleared, no Frame_done. Erase has priority over every other event.
- Expose=1 during CAPTURE: restart the frame. Go to ARMED, clear counters, keep Frame_err.
- Expose=1 during STREAM: ignored. The frame finishes first.
- Simultaneous events: adc_rise in the same cycle as Expose 1→0 in ARMED counts as an ARMED error, not a sample.
- Frame_err stays sticky until the next IDLE→ARMED transition or Reset.
- Busy = (state != IDLE).

Decomposition:
- Shared package (camera_pkg): state enum typedef, DATA_W default constant, and the NRE active-low encoding constants, shared with the exposure-control FSM.
- One sub-module: pixel_frame_buffer. It is a 2*COLS × DATA_W register file with a single write port (row, col, data, we) and a combinational read port.
- The FSM, counters and handshake stay in the top module.

Test Plan:
- Nominal frame, COLS=2: Expose pulse; then NRE_1=0 with ADC edges carrying 0x11, 0x22; then NRE_2=0 with 0x33, 0x44. Out_ready=1 → outputs (0,0,0x11), (0,1,0x22), (1,0,0x33), (1,1,0x44) on consecutive cycles; Frame_done pulses once; Frame_err=0.
- Backpressure: same frame, Out_ready toggled 0/1 every cycle → each pixel held stable while stalled; exactly 4 transfers in order; Frame_done after the 4th.
- Protocol error: in CAPTURE, ADC edge with NRE_1=NRE_2=0 carrying 0xAA → Frame_err=1, 0xAA never appears on output; the frame completes normally with the 4 valid samples.
- Overflow: 3 ADC edges with NRE_1=0 (0x01, 0x02, 0x03) → Frame_err=1; row 1 outputs 0x01, 0x02 only.
- Erase abort: Erase=1 for 1 cycle after the 2nd pixel transfer in STREAM → Out_valid=0 next cycle, state IDLE, no Frame_done; a following full frame captures and streams correctly.
- Reset mid-capture: Reset after 3 samples → all outputs 0, Busy=0. A new frame requires Expose again, and its ADC edges are captured from column 0.
